mult_share_arbiter: RTL and testbench

Round-robin arbiter and pipeline sequencer that shares one signed fixed-point multiplier (my_mult) between NUM_REQ requesters in the SPGD datapath. Typical requesters are the per-channel gain, perturbation and gradient-update stages. It accepts operand pairs over a valid/ready handshake and registers the multiplier input and output. Each result is returned to its originating requester with a fixed 2-cycle latency. Sits in the ADC_CLK domain ahead of the DAC output scaling.

---
 rtl/mult_share_arbiter.sv | 130 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin share of one signed fixed-point multiplier
// between NUM_REQ requesters, with registered multiplier input and output.
//
// Ports:
//   ADC_CLK   - clock, all logic on the rising edge
//   RESET     - synchronous active-high reset
//   ENABLE    - 1 = new grants allowed, 0 = drain in-flight ops only
//   REQ_VALID - per-requester operand valid
//   REQ_READY - per-requester grant (one-hot or zero)
//   REQ_A/B   - flattened operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   RES_VALID - one-hot result strobe, one cycle
//   RES_ID    - requester index owning RES_DATA
//   RES_DATA  - registered product (A*B) >>> DEC_FORMAT
//   BUSY      - a stage-1 or stage-2 slot holds a valid op
//   OP_COUNT  - completed-operation counter, wraps at 2^32
module mult_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 14,
    parameter int INT_WIDTH  = 16,
    parameter int BIT_SHIFT  = 0,
    parameter int INT_FORMAT = 2,
    parameter int DEC_FORMAT = 16,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                            ADC_CLK,
    input  logic                            RESET,
    input  logic                            ENABLE,
    input  logic [NUM_REQ-1:0]              REQ_VALID,
    output logic [NUM_REQ-1:0]              REQ_READY,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_A,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_B,
    output logic [NUM_REQ-1:0]              RES_VALID,
    output logic [ID_WIDTH-1:0]             RES_ID,
    output logic [DATA_WIDTH-1:0]           RES_DATA,
    output logic                            BUSY,
    output logic [31:0]                     OP_COUNT
);

    // Elaboration-time sanity on the configuration.
    if (NUM_REQ < 2 || OUT_WIDTH < 1 || INT_WIDTH < 1 ||
        BIT_SHIFT < 0 || INT_FORMAT < 0 || DEC_FORMAT < 0 ||
        DEC_FORMAT >= 2 * DATA_WIDTH) begin : g_bad_cfg
        $error("mult_share_arbiter: illegal parameter set");
    end

    logic [ID_WIDTH-1:0]          rr_ptr;
    logic [ID_WIDTH-1:0]          grant_id;
    logic                         grant_any;

    logic                         v1;
    logic                         v2;
    logic [ID_WIDTH-1:0]          id1;
    logic [DATA_WIDTH-1:0]        a1;
    logic [DATA_WIDTH-1:0]        b1;

    logic signed [2*DATA_WIDTH-1:0] prod_full;
    logic signed [2*DATA_WIDTH-1:0] prod_shift;
    logic [DATA_WIDTH-1:0]          mult_p;
    logic                           unused_hi;

    // Scan from the RR pointer upward; first valid requester wins.
    // Only registered state, ENABLE, RESET and REQ_VALID feed this.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        REQ_READY = '0;
        if (ENABLE && !RESET) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (!grant_any && REQ_VALID[idx]) begin
                    grant_any = 1'b1;
                    grant_id  = ID_WIDTH'(idx);
                end
            end
        end
        if (grant_any) begin
            REQ_READY[grant_id] = 1'b1;
        end
    end

    // Shared multiplier, fed from the stage-1 registers.
    assign prod_full  = $signed({{DATA_WIDTH{a1[DATA_WIDTH-1]}}, a1}) *
                        $signed({{DATA_WIDTH{b1[DATA_WIDTH-1]}}, b1});
    assign prod_shift = prod_full >>> DEC_FORMAT;
    assign mult_p     = prod_shift[DATA_WIDTH-1:0];
    // Product is truncated to DATA_WIDTH; upper half is discarded.
    assign unused_hi  = ^prod_shift[2*DATA_WIDTH-1:DATA_WIDTH];

    always_ff @(posedge ADC_CLK) begin
        if (RESET) begin
            rr_ptr    <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            id1       <= '0;
            a1        <= '0;
            b1        <= '0;
            RES_VALID <= '0;
            RES_ID    <= '0;
            RES_DATA  <= '0;
            OP_COUNT  <= '0;
        end else begin
            v1 <= grant_any;
            if (grant_any) begin
                a1  <= REQ_A[grant_id*DATA_WIDTH +: DATA_WIDTH];
                b1  <= REQ_B[grant_id*DATA_WIDTH +: DATA_WIDTH];
                id1 <= grant_id;
                if (grant_id == ID_WIDTH'(NUM_REQ - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_id + 1'b1;
                end
            end
            v2        <= v1;
            RES_VALID <= '0;
            // Result regs hold their last value between strobes.
            if (v1) begin
                RES_VALID[id1] <= 1'b1;
                RES_ID         <= id1;
                RES_DATA       <= mult_p;
                OP_COUNT       <= OP_COUNT + 32'd1;
            end
        end
    end

    assign BUSY = v1 | v2;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed self-checking bench for mult_share_arbiter.
// Inputs change #1 after a rising edge; outputs are sampled on falling edges.
module tb_mult_share_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   res_valid;
    logic [1:0]   res_id;
    logic [31:0]  res_data;
    logic         busy;
    logic [31:0]  op_count;

    int n_cmp  = 0;
    int n_fail = 0;

    mult_share_arbiter dut (
        .ADC_CLK   (clk),
        .RESET     (rst),
        .ENABLE    (en),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .REQ_A     (req_a),
        .REQ_B     (req_b),
        .RES_VALID (res_valid),
        .RES_ID    (res_id),
        .RES_DATA  (res_data),
        .BUSY      (busy),
        .OP_COUNT  (op_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req_valid = 4'b1111;
        req_a = '0; req_b = '0;
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_ready c=%0d got %b want 0000", c, req_ready);
            end
            n_cmp++;
            if (res_valid !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_res_valid c=%0d got %b want 0000", c, res_valid);
            end
            n_cmp++;
            if (op_count !== 32'd0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_cnt_busy c=%0d got %0d/%b want 0/0", c, op_count, busy);
            end
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant got %b want 0001", req_ready);
        end
        // Clean up the pending grant with another reset.
        rst = 1'b1;
        step();
        rst = 1'b0; req_valid = 4'b0000;
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_a[64 +: 32] = 32'h0001_0000;
        req_b[64 +: 32] = 32'h0002_0000;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_ready got %b want 0100", req_ready);
        end
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 4'b0000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_mid got %b/%b want 0000/1", res_valid, busy);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 4'b0100 || res_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_res got %b id %0d want 0100 id 2", res_valid, res_id);
        end
        n_cmp++;
        if (res_data !== 32'h0002_0000 || op_count !== 32'd1) begin
            n_fail++;
            $display("FAIL single_data got %h cnt %0d want 00020000 cnt 1", res_data, op_count);
        end
        step();
    endtask

    task automatic test_signed();
        req_valid = 4'b0010;
        req_a[32 +: 32] = 32'h0001_0000;
        req_b[32 +: 32] = 32'h800A_0000;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL signed_ready got %b want 0010", req_ready);
        end
        step();
        req_valid = 4'b0000;
        step();
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 4'b0010 || res_id !== 2'd1 || res_data !== 32'h800A_0000) begin
            n_fail++;
            $display("FAIL signed_res got %b id %0d data %h want 0010 id 1 data 800a0000",
                     res_valid, res_id, res_data);
        end
        n_cmp++;
        if (op_count !== 32'd2) begin
            n_fail++;
            $display("FAIL signed_cnt got %0d want 2", op_count);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 4'b0000 || res_data !== 32'h800A_0000) begin
            n_fail++;
            $display("FAIL signed_hold got %b data %h want 0000 data 800a0000",
                     res_valid, res_data);
        end
        step();
    endtask

    task automatic test_fairness();
        logic [31:0] exp_p [4];
        exp_p[0] = 32'h0003_0000;
        exp_p[1] = 32'h0008_0000;
        exp_p[2] = 32'h000F_0000;
        exp_p[3] = 32'h0018_0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_a = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
        req_b = {32'h0006_0000, 32'h0005_0000, 32'h0004_0000, 32'h0003_0000};
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            n_cmp++;
            if (req_ready !== ((c < 8) ? (4'b0001 << (c % 4)) : 4'b0000)) begin
                n_fail++;
                $display("FAIL fair_grant c=%0d got %b", c, req_ready);
            end
            if (c >= 2) begin
                n_cmp++;
                if (res_valid !== (4'b0001 << ((c - 2) % 4)) ||
                    res_id !== 2'((c - 2) % 4) ||
                    res_data !== exp_p[(c - 2) % 4]) begin
                    n_fail++;
                    $display("FAIL fair_res c=%0d got %b id %0d data %h want id %0d data %h",
                             c, res_valid, res_id, res_data, (c - 2) % 4, exp_p[(c - 2) % 4]);
                end
            end
            step();
        end
        n_cmp++;
        if (op_count !== 32'd8) begin
            n_fail++;
            $display("FAIL fair_cnt got %0d want 8", op_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] b_tbl [5];
        logic [31:0] p_tbl [5];
        b_tbl[0] = 32'h0002_0000; p_tbl[0] = 32'h0001_0000;
        b_tbl[1] = 32'h0004_0000; p_tbl[1] = 32'h0002_0000;
        b_tbl[2] = 32'hFFFA_0000; p_tbl[2] = 32'hFFFD_0000;
        b_tbl[3] = 32'h0010_0000; p_tbl[3] = 32'h0008_0000;
        b_tbl[4] = 32'hFFFF_0000; p_tbl[4] = 32'hFFFF_8000;
        req_a[96 +: 32] = 32'h0000_8000;
        for (int c = 0; c < 7; c++) begin
            req_valid = (c < 5) ? 4'b1000 : 4'b0000;
            if (c < 5) req_b[96 +: 32] = b_tbl[c];
            @(negedge clk);
            n_cmp++;
            if (req_ready !== ((c < 5) ? 4'b1000 : 4'b0000)) begin
                n_fail++;
                $display("FAIL b2b_grant c=%0d got %b", c, req_ready);
            end
            if (c >= 2) begin
                n_cmp++;
                if (res_valid !== 4'b1000 || res_id !== 2'd3 || res_data !== p_tbl[c - 2]) begin
                    n_fail++;
                    $display("FAIL b2b_res c=%0d got %b id %0d data %h want 1000 id 3 data %h",
                             c, res_valid, res_id, res_data, p_tbl[c - 2]);
                end
            end
            if (c >= 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_busy c=%0d got %b want 1", c, busy);
                end
            end
            step();
        end
        n_cmp++;
        if (op_count !== 32'd13 || res_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_cnt got %0d/%b want 13/0000", op_count, res_valid);
        end
    endtask

    task automatic test_enable_drain();
        req_valid = 4'b0001;
        req_a[0 +: 32] = 32'h0003_0000;
        req_b[0 +: 32] = 32'h0002_0000;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL en_grant got %b want 0001", req_ready);
        end
        step();
        en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0000 || busy !== 1'b1 || res_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL en_off got rdy %b busy %b res %b want 0000/1/0000",
                     req_ready, busy, res_valid);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 4'b0001 || res_data !== 32'h0006_0000 ||
            busy !== 1'b1 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL en_drain got res %b data %h busy %b rdy %b want 0001 00060000 1 0000",
                     res_valid, res_data, busy, req_ready);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 4'b0000 || busy !== 1'b0 || op_count !== 32'd14) begin
            n_fail++;
            $display("FAIL en_idle got res %b busy %b cnt %0d want 0000/0/14",
                     res_valid, busy, op_count);
        end
        step();
        en = 1'b1; req_valid = 4'b0000;
    endtask

    task automatic test_reset_midflight();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b0010;
        req_a[32 +: 32] = 32'h0001_0000;
        req_b[32 +: 32] = 32'h0003_0000;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL rmid_grant got %b want 0010", req_ready);
        end
        step();
        req_valid = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (res_valid !== 4'b0000 || op_count !== 32'd0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_flush c=%0d got res %b cnt %0d busy %b want 0000/0/0",
                         c, res_valid, op_count, busy);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_signed();
        test_fairness();
        test_back_to_back();
        test_enable_drain();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
